quaffle_controller: RTL and testbench

Game-logic stage that feeds the VGA pixel controller. Once per video frame it moves the quaffle (ball), bounces it off the top and bottom walls and both team paddles, and detects goals. It also keeps both team scores and sequences serve, play, goal and game-over. It consumes the paddle positions from the two team controllers and the frame tick from the vertical counter. It produces registered ball position, scores and game-over for the renderer.

---
 rtl/quidditch_pkg.sv | 26 ++
 rtl/quaffle_serve_timer.sv | 37 +++
 rtl/quaffle_controller.sv | 192 +++++++++++++++++++
 tb/tb_quaffle_controller.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/quidditch_pkg.sv
// Shared screen constants, game FSM states and direction encoding for the
// quaffle game-logic stage.
package quidditch_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    GOAL  = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  // DIR_POS is right on the x axis and down on the y axis.
  typedef enum logic {
    DIR_NEG = 1'b0,
    DIR_POS = 1'b1
  } dir_t;

  function automatic logic v_overlap(input logic [10:0] y, input logic [10:0] pos,
                                     input logic [10:0] ball, input logic [10:0] h);
    return ((y + ball) > pos) && (y < (pos + h));
  endfunction

endpackage

// File: rtl/quaffle_serve_timer.sv
// Frame counter with clear and enable; done is high while the count sits at
// FRAMES-1 and an enabled step from there wraps back to zero.
module quaffle_serve_timer #(
  parameter int FRAMES = 60
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_en,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam int CW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign done_o = (cnt_q == CW'(FRAMES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = done_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clk_en) begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/quaffle_controller.sv
// Per-frame quaffle motion, wall/paddle bounces, goal detection, scoring and
// serve/play/goal/over sequencing for the VGA renderer.
module quaffle_controller
  import quidditch_pkg::*;
#(
  parameter int H_ACTIVE     = quidditch_pkg::H_ACTIVE,
  parameter int V_ACTIVE     = quidditch_pkg::V_ACTIVE,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE1_X    = 16,
  parameter int PADDLE2_X    = 616,
  parameter int SPEED        = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        frame_tick,
  input  logic [9:0]  team1_ver_pos,
  input  logic [9:0]  team2_ver_pos,
  output logic [9:0]  ball_x,
  output logic [9:0]  ball_y,
  output logic [3:0]  score1,
  output logic [3:0]  score2,
  output logic        game_over,
  output game_state_t dbg_state_o
);

  localparam logic [10:0] X_MAX   = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic [10:0] Y_MAX   = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic [9:0]  X_MID   = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]  Y_MID   = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [10:0] P1_FACE = 11'(PADDLE1_X + PADDLE_W);
  localparam logic [10:0] P2_FACE = 11'(PADDLE2_X);
  localparam logic [10:0] SPD     = 11'(SPEED);
  localparam logic [10:0] BSZ     = 11'(BALL_SIZE);
  localparam logic [10:0] PH      = 11'(PADDLE_H);
  localparam logic [3:0]  WIN     = 4'(WIN_SCORE);

  game_state_t state_q, state_d;
  dir_t        dx_q, dx_d, dy_q, dy_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [3:0]  s1_q, s1_d, s2_q, s2_d;
  logic        over_q, over_d;

  logic        update, serve_done;
  logic [10:0] x, y, nx, ny;
  dir_t        ndx, ndy;
  logic        hit1, hit2, goal1, goal2;

  assign update = clk_en && frame_tick;
  assign x      = {1'b0, x_q};
  assign y      = {1'b0, y_q};

  quaffle_serve_timer #(
    .FRAMES (SERVE_FRAMES)
  ) u_serve_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .clr_i  (update && (state_q != SERVE)),
    .en_i   (update && (state_q == SERVE)),
    .done_o (serve_done)
  );

  always_comb begin
    ny  = y;
    ndy = dy_q;
    if (dy_q == DIR_POS) begin
      if (y + SPD >= Y_MAX) begin
        ny  = Y_MAX;
        ndy = DIR_NEG;
      end else begin
        ny = y + SPD;
      end
    end else if (y < SPD) begin
      ny  = '0;
      ndy = DIR_POS;
    end else begin
      ny = y - SPD;
    end
  end

  always_comb begin
    nx    = x;
    ndx   = dx_q;
    goal1 = 1'b0;
    goal2 = 1'b0;
    hit1  = (x >= P1_FACE) && (x < P1_FACE + SPD) &&
            v_overlap(y, {1'b0, team1_ver_pos}, BSZ, PH);
    hit2  = (x + BSZ <= P2_FACE) && (x + BSZ + SPD > P2_FACE) &&
            v_overlap(y, {1'b0, team2_ver_pos}, BSZ, PH);
    if (dx_q == DIR_NEG) begin
      if (hit1) begin
        nx  = P1_FACE;
        ndx = DIR_POS;
      end else if (x < SPD) begin
        goal2 = 1'b1;
      end else begin
        nx = x - SPD;
      end
    end else begin
      if (hit2) begin
        nx  = P2_FACE - BSZ;
        ndx = DIR_NEG;
      end else if (x + SPD > X_MAX) begin
        goal1 = 1'b1;
      end else begin
        nx = x + SPD;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    over_d  = over_q;
    if (update) begin
      unique case (state_q)
        SERVE: begin
          if (serve_done) state_d = PLAY;
        end
        PLAY: begin
          // A goal freezes the ball where it crossed, including y.
          if (goal1) begin
            s1_d    = s1_q + 4'd1;
            state_d = GOAL;
          end else if (goal2) begin
            s2_d    = s2_q + 4'd1;
            state_d = GOAL;
          end else begin
            x_d  = nx[9:0];
            y_d  = ny[9:0];
            dx_d = ndx;
            dy_d = ndy;
          end
        end
        GOAL: begin
          // dx_q still points at the conceding side, which is the serve direction.
          x_d = X_MID;
          y_d = Y_MID;
          if ((dx_q == DIR_POS) ? (s1_q == WIN) : (s2_q == WIN)) begin
            state_d = OVER;
            over_d  = 1'b1;
          end else begin
            state_d = SERVE;
          end
        end
        OVER: begin
        end
        default: state_d = SERVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SERVE;
      x_q     <= X_MID;
      y_q     <= Y_MID;
      dx_q    <= DIR_POS;
      dy_q    <= DIR_POS;
      s1_q    <= '0;
      s2_q    <= '0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      over_q  <= over_d;
    end
  end

  assign ball_x      = x_q;
  assign ball_y      = y_q;
  assign score1      = s1_q;
  assign score2      = s2_q;
  assign game_over   = over_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_quaffle_controller.sv
// Directed bench for quaffle_controller: serve timing, wall and paddle
// bounces, goals both ways, win/game-over and asynchronous reset.
module tb_quaffle_controller;
  import quidditch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic        frame_tick;
  logic [9:0]  team1_ver_pos;
  logic [9:0]  team2_ver_pos;
  logic [9:0]  ball_x;
  logic [9:0]  ball_y;
  logic [3:0]  score1;
  logic [3:0]  score2;
  logic        game_over;
  game_state_t dbg_state;

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q[$];

  quaffle_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clk_en        (clk_en),
    .frame_tick    (frame_tick),
    .team1_ver_pos (team1_ver_pos),
    .team2_ver_pos (team2_ver_pos),
    .ball_x        (ball_x),
    .ball_y        (ball_y),
    .score1        (score1),
    .score2        (score2),
    .game_over     (game_over),
    .dbg_state_o   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_ball(input string tag, input int ex, input int ey);
    check({tag, ".x"}, 32'(ball_x), 32'(ex));
    check({tag, ".y"}, 32'(ball_y), 32'(ey));
  endtask

  task automatic check_st(input string tag, input game_state_t st);
    check({tag, ".state"}, 32'(dbg_state), 32'(st));
  endtask

  task automatic check_scores(input string tag, input int s1, input int s2, input int go);
    check({tag, ".score1"}, 32'(score1), 32'(s1));
    check({tag, ".score2"}, 32'(score2), 32'(s2));
    check({tag, ".game_over"}, 32'(game_over), 32'(go));
  endtask

  // One update = one clk_en cycle carrying frame_tick, then an idle enable cycle.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); clk_en = 1'b1; frame_tick = 1'b1;
      @(negedge clk); clk_en = 1'b0; frame_tick = 1'b0;
      @(negedge clk); clk_en = 1'b1;
      @(negedge clk); clk_en = 1'b0;
    end
  endtask

  task automatic async_reset_pulse();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b0; frame_tick = 1'b0;
    team1_ver_pos = 10'd150; team2_ver_pos = 10'd400;
    repeat (3) @(negedge clk);
    check_ball("reset", 316, 236);
    check_scores("reset", 0, 0, 0);
    check_st("reset", SERVE);
    rst_n = 1'b1;

    // Serve hold: 59 updates still SERVE, 60th moves to PLAY, 61st moves the ball.
    run(59); check_st("serve59", SERVE); check_ball("serve59", 316, 236);
    run(1);  check_st("serve60", PLAY);  check_ball("serve60", 316, 236);
    run(1);  check_ball("play1", 318, 238);

    // Bottom wall bounce.
    run(116); check_ball("pre_bottom", 550, 470);
    run(1);   check_ball("bottom", 552, 472);
    run(1);   check_ball("after_bottom", 554, 470);

    // Team2 paddle hit at pos 400.
    run(27); check_ball("pre_hit2", 608, 416);
    run(1);  check_ball("hit2", 608, 414);
    run(1);  check_ball("after_hit2", 606, 412);

    // Top wall: y reaches 0, then holds 0 for the turnaround update.
    run(206); check_ball("top_reach", 194, 0);
    run(1);   check_ball("top_turn", 192, 0);
    run(1);   check_ball("after_top", 190, 2);

    // Team1 paddle hit at pos 150.
    run(83); check_ball("pre_hit1", 24, 168);
    team2_ver_pos = 10'd900;
    run(1);  check_ball("hit1", 24, 170);
    run(1);  check_ball("after_hit1", 26, 172);

    // Team2 misses: team1 scores at the right edge.
    run(303); check_ball("pre_goal1", 632, 166); check_scores("pre_goal1", 0, 0, 0);
    run(1);   check_ball("goal1", 632, 166); check_scores("goal1", 1, 0, 0); check_st("goal1", GOAL);
    run(1);   check_ball("reserve1", 316, 236); check_st("reserve1", SERVE);

    // Second rally: serve goes right and up, team2 hits at pos 30, team1 misses.
    team1_ver_pos = 10'd900; team2_ver_pos = 10'd30;
    run(60);  check_st("serve_r2", PLAY);
    run(1);   check_ball("r2_m1", 318, 234);
    run(117); check_ball("r2_top", 552, 0);
    run(1);   check_ball("r2_turn", 554, 0);
    run(27);  check_ball("r2_pre_hit2", 608, 54);
    run(1);   check_ball("r2_hit2", 608, 56);
    run(1);   check_ball("r2_after_hit2", 606, 58);
    run(303); check_ball("r2_pre_goal", 0, 280);
    run(1);   check_ball("r2_goal", 0, 280); check_scores("r2_goal", 1, 1, 0); check_st("r2_goal", GOAL);
    run(1);   check_ball("r2_reserve", 316, 236); check_st("r2_reserve", SERVE);
    run(60);  check_st("r2_serve_done", PLAY);
    run(1);   check_ball("r3_m1", 314, 234);

    // Team2 goals 2..7; serve toward team1, dir_y alternates each round.
    exp_q = {10'd78, 10'd392, 10'd78, 10'd392, 10'd78, 10'd392};
    for (int g = 2; g <= 7; g++) begin
      logic [9:0] ey;
      if (g > 2) run(62);
      run(158);
      ey = exp_q.pop_front();
      check_ball($sformatf("goal2_%0d", g), 0, int'(ey));
      check_scores($sformatf("goal2_%0d", g), 1, g, 0);
      check_st($sformatf("goal2_%0d", g), GOAL);
    end

    // One update after the winning goal the game is over.
    run(1);
    check_st("over", OVER); check_ball("over", 316, 236); check_scores("over", 1, 7, 1);
    team1_ver_pos = 10'd200; team2_ver_pos = 10'd200;
    run(5);
    check_st("over_hold", OVER); check_ball("over_hold", 316, 236); check_scores("over_hold", 1, 7, 1);

    // Asynchronous reset out of OVER, between clock edges with clk_en low.
    async_reset_pulse();
    check_scores("arst_over", 0, 0, 0); check_ball("arst_over", 316, 236); check_st("arst_over", SERVE);
    @(negedge clk); rst_n = 1'b1;

    // Asynchronous reset mid-PLAY.
    team1_ver_pos = 10'd900; team2_ver_pos = 10'd900;
    run(65); check_ball("mid_play", 326, 246);
    async_reset_pulse();
    check_ball("arst_play", 316, 236); check_st("arst_play", SERVE);
    @(negedge clk); rst_n = 1'b1;

    // frame_tick without clk_en is not an update: serve count is untouched.
    frame_tick = 1'b1;
    repeat (10) @(negedge clk);
    frame_tick = 1'b0;
    check_ball("tick_no_en", 316, 236);
    run(59); check_st("tick_no_en_serve59", SERVE);
    run(1);  check_st("tick_no_en_serve60", PLAY);
    run(1);  check_ball("tick_no_en_play1", 318, 238);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
